nn_param_streamer: RTL and testbench

Hardware sequencer that drives the network's configuration and data ports (weight_value/valid_weight, bias_value/valid_bias, layer_no/neuron_no, my_input/valid_input). It replaces file-driven loading with on-chip memory reads. For one layer, it streams every neuron's weight burst and bias from a parameter memory, then streams one image's pixels. It sits between a single-port synchronous ROM/RAM and the network top level, which has no backpressure.

---
 rtl/nn_param_streamer_if.sv | 37 +++
 rtl/nn_param_streamer.sv | 197 +++++++++++++++++++
 tb/tb_nn_param_streamer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_param_streamer_if.sv
// Memory read port plus the network-facing load/stream port of nn_param_streamer.
// master: the streamer (issues reads, drives the network strobes).
// slave:  the memory/network side (returns read data, consumes strobes).
interface nn_param_streamer_if #(
  parameter int data_width = 16,
  parameter int ADDR_W     = 16
);
  logic                  mem_rd_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [31:0]           mem_rdata;
  logic [31:0]           weight_value;
  logic                  valid_weight;
  logic [31:0]           bias_value;
  logic                  valid_bias;
  logic [31:0]           layer_no;
  logic [31:0]           neuron_no;
  logic [data_width-1:0] my_input;
  logic                  valid_input;

  modport master (
    output mem_rd_en, mem_addr,
    input  mem_rdata,
    output weight_value, valid_weight,
    output bias_value, valid_bias,
    output layer_no, neuron_no,
    output my_input, valid_input
  );

  modport slave (
    input  mem_rd_en, mem_addr,
    output mem_rdata,
    input  weight_value, valid_weight,
    input  bias_value, valid_bias,
    input  layer_no, neuron_no,
    input  my_input, valid_input
  );
endinterface

// File: rtl/nn_param_streamer.sv
// Streams one layer's weights/biases and then one image from a synchronous
// single-port memory into the network load port, without gaps.
//
// state | meaning
// IDLE  | waiting for start
// NSEL  | one bubble cycle; neuron_no/layer_no updated for the next burst
// WGT   | weight w of neuron n on the output (num_weights cycles)
// BIAS  | bias of neuron n on the output (one cycle)
// IGAP  | one bubble cycle before the image
// INP   | pixel w of the image on the output (num_weights cycles)
// FIN   | done pulse, busy drops
//
// Outputs are registered from the current state, so the strobe for a state
// appears one cycle after that state. Memory has one cycle of read latency,
// so each read is issued from the state two steps ahead (la below).
// start and abort are registered once before the FSM acts on them.
module nn_param_streamer #(
  parameter int data_width  = 16,
  parameter int num_weights = 784,
  parameter int no_neuron   = 30,
  parameter int layer_id    = 1,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              skip_params,
  input  logic [ADDR_W-1:0] img_base,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  nn_param_streamer_if.master bus
);

  localparam int W_W = $clog2(num_weights + 1);
  localparam int N_W = $clog2(no_neuron + 1);
  localparam logic [31:0] STRIDE   = 32'(num_weights + 1);
  localparam logic [31:0] BIAS_OFS = 32'(num_weights);

  typedef enum logic [2:0] {
    IDLE, NSEL, WGT, BIAS, IGAP, INP, FIN
  } state_t;

  typedef struct packed {
    state_t         st;
    logic [W_W-1:0] w;
    logic [N_W-1:0] n;
  } pos_t;

  state_t            state_q;
  logic [W_W-1:0]    w_q;
  logic [N_W-1:0]    n_q;
  logic              start_q;
  logic              abort_q;
  logic              skip_q;
  logic [ADDR_W-1:0] base_q;

  pos_t              cur;
  pos_t              nxt;
  pos_t              la;
  logic              la_rd;
  logic [ADDR_W-1:0] la_addr;
  logic [31:0]       nbase;
  logic              start_ok;

  // Free-running sequence once a load is in progress; IDLE and FIN fall back to IDLE.
  function automatic pos_t step(input pos_t p);
    pos_t r;
    r = p;
    case (p.st)
      NSEL: begin
        r.st = WGT;
        r.w  = '0;
      end
      WGT: begin
        if (p.w == W_W'(num_weights - 1)) r.st = BIAS;
        else r.w = p.w + 1'b1;
      end
      BIAS: begin
        if (p.n == N_W'(no_neuron - 1)) begin
          r.st = IGAP;
        end else begin
          r.st = NSEL;
          r.n  = p.n + 1'b1;
        end
      end
      IGAP: begin
        r.st = INP;
        r.w  = '0;
      end
      INP: begin
        if (p.w == W_W'(num_weights - 1)) r.st = FIN;
        else r.w = p.w + 1'b1;
      end
      default: r.st = IDLE;
    endcase
    return r;
  endfunction

  assign start_ok = start && !abort && (state_q == IDLE) && !start_q;

  // Next position, plus the one after it that decides which word to fetch now.
  always_comb begin
    cur = '{st: state_q, w: w_q, n: n_q};
    nxt = cur;
    if (abort_q) begin
      nxt.st = IDLE;
    end else if (state_q == IDLE) begin
      if (start_q) begin
        nxt.st = skip_q ? IGAP : NSEL;
        nxt.w  = '0;
        nxt.n  = '0;
      end
    end else begin
      nxt = step(cur);
    end
    la = step(nxt);

    nbase   = 32'(la.n) * STRIDE;
    la_rd   = 1'b0;
    la_addr = '0;
    case (la.st)
      WGT: begin
        la_rd   = 1'b1;
        la_addr = ADDR_W'(nbase + 32'(la.w));
      end
      BIAS: begin
        la_rd   = 1'b1;
        la_addr = ADDR_W'(nbase + BIAS_OFS);
      end
      INP: begin
        la_rd   = 1'b1;
        la_addr = base_q + ADDR_W'(la.w);
      end
      default: begin
        la_rd   = 1'b0;
        la_addr = '0;
      end
    endcase
  end

  // Sequencer state, request capture and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      w_q              <= '0;
      n_q              <= '0;
      start_q          <= 1'b0;
      abort_q          <= 1'b0;
      skip_q           <= 1'b0;
      base_q           <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      bus.mem_rd_en    <= 1'b0;
      bus.mem_addr     <= '0;
      bus.weight_value <= '0;
      bus.valid_weight <= 1'b0;
      bus.bias_value   <= '0;
      bus.valid_bias   <= 1'b0;
      bus.layer_no     <= '0;
      bus.neuron_no    <= '0;
      bus.my_input     <= '0;
      bus.valid_input  <= 1'b0;
    end else begin
      abort_q <= abort;
      start_q <= start_ok;
      if (start_ok) begin
        skip_q <= skip_params;
        base_q <= img_base;
      end

      state_q <= nxt.st;
      w_q     <= nxt.w;
      n_q     <= nxt.n;
      busy    <= (nxt.st != IDLE);
      done    <= (state_q == FIN) && !abort_q;

      bus.mem_rd_en <= la_rd;
      if (la_rd) bus.mem_addr <= la_addr;

      bus.valid_weight <= (state_q == WGT) && !abort_q;
      if ((state_q == WGT) && !abort_q) bus.weight_value <= bus.mem_rdata;

      bus.valid_bias <= (state_q == BIAS) && !abort_q;
      if ((state_q == BIAS) && !abort_q) bus.bias_value <= bus.mem_rdata;

      bus.valid_input <= (state_q == INP) && !abort_q;
      if ((state_q == INP) && !abort_q) bus.my_input <= bus.mem_rdata[data_width-1:0];

      if ((state_q == NSEL) && !abort_q) begin
        bus.neuron_no <= 32'(n_q) + 32'd1;
        bus.layer_no  <= 32'(layer_id);
      end
    end
  end

endmodule

// File: tb/tb_nn_param_streamer.sv
// Scoreboard bench for nn_param_streamer with a small layer (2 neurons x 4 weights).
// Memory word k holds k. Cycle c is observed on the falling edge after the
// c-th rising edge counted from the edge that samples start.
module tb_nn_param_streamer;
  localparam int NW = 4;
  localparam int NN = 2;

  typedef struct {
    int          cyc;
    int          kind;   // 0 weight, 1 bias, 2 pixel
    logic [31:0] data;
    logic [31:0] neuron;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        skip_params;
  logic [15:0] img_base;
  logic        abort;
  logic        busy;
  logic        done;

  int checks = 0;
  int passed = 0;
  ev_t exp_q[$];

  nn_param_streamer_if #(.data_width(16), .ADDR_W(16)) bus ();

  nn_param_streamer #(
    .data_width(16), .num_weights(NW), .no_neuron(NN), .layer_id(1), .ADDR_W(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .skip_params(skip_params),
    .img_base(img_base), .abort(abort), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= 32'(bus.mem_addr);
  end

  // Expected strobe stream for one run; events after maxc are not pushed.
  task automatic push_load(input logic [15:0] base, input bit skip, input int maxc,
                           output int done_cyc);
    int c;
    ev_t e;
    c = 3;
    if (!skip) begin
      for (int n = 0; n < NN; n++) begin
        for (int w = 0; w < NW; w++) begin
          e = '{c, 0, 32'(n * (NW + 1) + w), 32'(n + 1)};
          if (c <= maxc) exp_q.push_back(e);
          c++;
        end
        e = '{c, 1, 32'(n * (NW + 1) + NW), 32'(n + 1)};
        if (c <= maxc) exp_q.push_back(e);
        c += 2;
      end
    end
    for (int i = 0; i < NW; i++) begin
      logic [15:0] px;
      px = base + 16'(i);
      e = '{c, 2, 32'(px), 32'd0};
      if (c <= maxc) exp_q.push_back(e);
      c++;
    end
    done_cyc = c;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.mem_rd_en, bus.mem_addr, bus.weight_value, bus.valid_weight, bus.bias_value,
         bus.valid_bias, bus.layer_no, bus.neuron_no, bus.my_input, bus.valid_input,
         busy, done} !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b vw=%b vb=%b vi=%b rd=%b nn=%0d need all 0",
               busy, done, bus.valid_weight, bus.valid_bias, bus.valid_input, bus.mem_rd_en,
               bus.neuron_no);
    else passed++;
  endtask

  // Full load; with extra=1, start is also pulsed at cycles 5 and 19 and must be ignored.
  task automatic test_full_load(input bit extra);
    int dc, nw_cnt, nb_cnt, ni_cnt, okind;
    logic [31:0] odata;
    ev_t e;
    exp_q.delete();
    nw_cnt = 0; nb_cnt = 0; ni_cnt = 0;
    push_load(16'd100, 1'b0, 1000, dc);
    @(negedge clk);
    start = 1'b1; skip_params = 1'b0; img_base = 16'd100;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      start = extra && ((c + 1 == 5) || (c + 1 == 19));
      checks++;
      if (32'(bus.valid_weight) + 32'(bus.valid_bias) + 32'(bus.valid_input) > 1)
        $display("FAIL strobe_onehot cyc=%0d got vw=%b vb=%b vi=%b need at most one",
                 c, bus.valid_weight, bus.valid_bias, bus.valid_input);
      else passed++;
      if (bus.valid_weight || bus.valid_bias || bus.valid_input) begin
        okind = bus.valid_weight ? 0 : (bus.valid_bias ? 1 : 2);
        odata = bus.valid_weight ? bus.weight_value :
                (bus.valid_bias ? bus.bias_value : 32'(bus.my_input));
        nw_cnt += int'(bus.valid_weight); nb_cnt += int'(bus.valid_bias);
        ni_cnt += int'(bus.valid_input);
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL full_unexpected_strobe cyc=%0d got kind=%0d data=%0d need none",
                   c, okind, odata);
        end else begin
          e = exp_q.pop_front();
          if (c !== e.cyc || okind !== e.kind || odata !== e.data ||
              (e.kind != 2 && (bus.neuron_no !== e.neuron || bus.layer_no !== 32'd1)))
            $display("FAIL full_event got cyc=%0d kind=%0d data=%0d neuron=%0d layer=%0d need cyc=%0d kind=%0d data=%0d neuron=%0d layer=1",
                     c, okind, odata, bus.neuron_no, bus.layer_no, e.cyc, e.kind, e.data, e.neuron);
          else passed++;
        end
      end
      checks++;
      if (done !== (c == dc)) $display("FAIL full_done cyc=%0d got %b need %b", c, done, c == dc);
      else passed++;
      checks++;
      if (busy !== (c >= 1 && c < dc)) $display("FAIL full_busy cyc=%0d got %b need %b", c, busy, c >= 1 && c < dc);
      else passed++;
      checks++;
      if (bus.mem_rd_en && !busy) $display("FAIL full_rd_idle cyc=%0d got mem_rd_en=1 need 0", c);
      else passed++;
      if (c == 2 || c == 8) begin
        checks++;
        if (bus.neuron_no !== 32'(c / 6 + 1) || bus.layer_no !== 32'd1)
          $display("FAIL full_nsel cyc=%0d got neuron=%0d layer=%0d need neuron=%0d layer=1",
                   c, bus.neuron_no, bus.layer_no, c / 6 + 1);
        else passed++;
      end
    end
    start = 1'b0;
    checks++;
    if (exp_q.size() != 0) $display("FAIL full_missing got %0d events left need 0", exp_q.size());
    else passed++;
    checks++;
    if (nw_cnt != 8 || nb_cnt != 2 || ni_cnt != 4)
      $display("FAIL full_counts got w=%0d b=%0d i=%0d need w=8 b=2 i=4", nw_cnt, nb_cnt, ni_cnt);
    else passed++;
  endtask

  task automatic test_skip();
    int dc, okind;
    logic [31:0] odata;
    ev_t e;
    exp_q.delete();
    push_load(16'hFFFE, 1'b1, 1000, dc);
    @(negedge clk);
    start = 1'b1; skip_params = 1'b1; img_base = 16'hFFFE;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.valid_weight || bus.valid_bias || bus.valid_input) begin
        okind = bus.valid_weight ? 0 : (bus.valid_bias ? 1 : 2);
        odata = bus.valid_weight ? bus.weight_value :
                (bus.valid_bias ? bus.bias_value : 32'(bus.my_input));
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL skip_unexpected_strobe cyc=%0d got kind=%0d data=%h need none", c, okind, odata);
        end else begin
          e = exp_q.pop_front();
          if (c !== e.cyc || okind !== e.kind || odata !== e.data)
            $display("FAIL skip_event got cyc=%0d kind=%0d data=%h need cyc=%0d kind=%0d data=%h",
                     c, okind, odata, e.cyc, e.kind, e.data);
          else passed++;
        end
      end
      checks++;
      if (done !== (c == dc)) $display("FAIL skip_done cyc=%0d got %b need %b", c, done, c == dc);
      else passed++;
    end
    skip_params = 1'b0;
    checks++;
    if (exp_q.size() != 0) $display("FAIL skip_missing got %0d events left need 0", exp_q.size());
    else passed++;
  endtask

  task automatic test_abort();
    int dc, okind;
    logic [31:0] odata;
    ev_t e;
    exp_q.delete();
    push_load(16'd100, 1'b0, 10, dc);
    @(negedge clk);
    start = 1'b1; skip_params = 1'b0; img_base = 16'd100;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      start = 1'b0;
      abort = (c + 1 == 10);
      if (bus.valid_weight || bus.valid_bias || bus.valid_input) begin
        okind = bus.valid_weight ? 0 : (bus.valid_bias ? 1 : 2);
        odata = bus.valid_weight ? bus.weight_value :
                (bus.valid_bias ? bus.bias_value : 32'(bus.my_input));
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL abort_unexpected_strobe cyc=%0d got kind=%0d data=%0d need none", c, okind, odata);
        end else begin
          e = exp_q.pop_front();
          if (c !== e.cyc || okind !== e.kind || odata !== e.data || bus.neuron_no !== e.neuron)
            $display("FAIL abort_event got cyc=%0d kind=%0d data=%0d neuron=%0d need cyc=%0d kind=%0d data=%0d neuron=%0d",
                     c, okind, odata, bus.neuron_no, e.cyc, e.kind, e.data, e.neuron);
          else passed++;
        end
      end
      checks++;
      if (done !== 1'b0) $display("FAIL abort_done cyc=%0d got 1 need 0", c);
      else passed++;
      checks++;
      if (busy !== (c >= 1 && c <= 10)) $display("FAIL abort_busy cyc=%0d got %b need %b", c, busy, c >= 1 && c <= 10);
      else passed++;
    end
    abort = 1'b0;
    checks++;
    if (exp_q.size() != 0) $display("FAIL abort_missing got %0d events left need 0", exp_q.size());
    else passed++;
    test_full_load(1'b0);
  endtask

  task automatic test_reset_mid();
    int dc, okind;
    logic [31:0] odata;
    ev_t e;
    exp_q.delete();
    push_load(16'd100, 1'b0, 11, dc);
    @(negedge clk);
    start = 1'b1; skip_params = 1'b0; img_base = 16'd100;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.valid_weight || bus.valid_bias || bus.valid_input) begin
        okind = bus.valid_weight ? 0 : (bus.valid_bias ? 1 : 2);
        odata = bus.valid_weight ? bus.weight_value :
                (bus.valid_bias ? bus.bias_value : 32'(bus.my_input));
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL rstmid_unexpected_strobe cyc=%0d got kind=%0d data=%0d need none", c, okind, odata);
        end else begin
          e = exp_q.pop_front();
          if (c !== e.cyc || okind !== e.kind || odata !== e.data)
            $display("FAIL rstmid_event got cyc=%0d kind=%0d data=%0d need cyc=%0d kind=%0d data=%0d",
                     c, okind, odata, e.cyc, e.kind, e.data);
          else passed++;
        end
      end
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.mem_rd_en, bus.mem_addr, bus.weight_value, bus.valid_weight, bus.bias_value,
         bus.valid_bias, bus.layer_no, bus.neuron_no, bus.my_input, bus.valid_input,
         busy, done} !== '0)
      $display("FAIL rstmid_outputs got busy=%b vw=%b wv=%0d nn=%0d rd=%b need all 0",
               busy, bus.valid_weight, bus.weight_value, bus.neuron_no, bus.mem_rd_en);
    else passed++;
    checks++;
    if (exp_q.size() != 0) $display("FAIL rstmid_missing got %0d events left need 0", exp_q.size());
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_full_load(1'b0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; skip_params = 1'b0; img_base = '0; abort = 1'b0;
    #3;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_full_load(1'b0);
    test_skip();
    test_abort();
    test_full_load(1'b1);
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
